// File: rtl/latch_bank_arbiter_pkg.sv
// Shared definitions for the latch bank write controller: FSM state encodings,
// default widths and the open-window counter width.
package latch_bank_arbiter_pkg;

  localparam int N_REQ_DEF       = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int OPEN_CYCLES_DEF = 2;

  // OPEN_CYCLES tops out at 15, so a 4-bit down-counter covers every legal load.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SETUP = 3'd2,
    ST_OPEN  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/latch_bank_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_winner+1 (mod N_REQ)
// and returns the first active requester as a one-hot grant and a binary index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   k;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(last_winner) + i) % N_REQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Round-robin write arbiter and enable sequencer for an external bank of
// active-low-reset transparent latches; every output comes straight from a flop.
//
// state | meaning
// IDLE  | waiting; clear (pending or arriving) wins over req
// CLEAR | latch bank reset held low for one cycle
// SETUP | winner data on latch_d, enable still low
// OPEN  | enable high for OPEN_CYCLES cycles
// HOLD  | enable low, data held, ack pulse to winner
module latch_bank_arbiter
  import latch_bank_arbiter_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OPEN_CYCLES = OPEN_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    clear_req,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       latch_d,
  output logic                    latch_enable,
  output logic                    latch_reset_n,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]  latch_d_q, latch_d_d;
  logic               latch_enable_q, latch_enable_d;
  logic               latch_reset_n_q, latch_reset_n_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;
  logic               clear_pending_q, clear_pending_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req         (req),
    .last_winner (last_winner_q),
    .grant       (arb_grant),
    .idx         (arb_idx)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    gnt_d           = gnt_q;
    ack_d           = '0;
    latch_d_d       = latch_d_q;
    latch_enable_d  = 1'b0;
    win_idx_d       = win_idx_q;
    last_winner_d   = last_winner_q;
    clear_pending_d = clear_pending_q | clear_req;

    case (state_q)
      ST_IDLE: begin
        if (clear_req || clear_pending_q) begin
          state_d         = ST_CLEAR;
          clear_pending_d = 1'b0;
        end else if (|req) begin
          state_d   = ST_SETUP;
          gnt_d     = arb_grant;
          win_idx_d = arb_idx;
          latch_d_d = req_data[int'(arb_idx)*DATA_W +: DATA_W];
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_SETUP: begin
        state_d        = ST_OPEN;
        cnt_d          = OPEN_LOAD;
        latch_enable_d = 1'b1;
      end
      ST_OPEN: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          ack_d   = gnt_q;
        end else begin
          cnt_d          = cnt_q - 1'b1;
          latch_enable_d = 1'b1;
        end
      end
      ST_HOLD: begin
        state_d       = ST_IDLE;
        gnt_d         = '0;
        last_winner_d = win_idx_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered against the next state so they line up with it.
    latch_reset_n_d = (state_d != ST_CLEAR);
    busy_d          = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      gnt_q           <= '0;
      ack_q           <= '0;
      latch_d_q       <= '0;
      latch_enable_q  <= 1'b0;
      latch_reset_n_q <= 1'b0;
      busy_q          <= 1'b0;
      win_idx_q       <= '0;
      last_winner_q   <= LAST_RST;
      clear_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      gnt_q           <= gnt_d;
      ack_q           <= ack_d;
      latch_d_q       <= latch_d_d;
      latch_enable_q  <= latch_enable_d;
      latch_reset_n_q <= latch_reset_n_d;
      busy_q          <= busy_d;
      win_idx_q       <= win_idx_d;
      last_winner_q   <= last_winner_d;
      clear_pending_q <= clear_pending_d;
    end
  end

  assign gnt           = gnt_q;
  assign ack           = ack_q;
  assign latch_d       = latch_d_q;
  assign latch_enable  = latch_enable_q;
  assign latch_reset_n = latch_reset_n_q;
  assign busy          = busy_q;

endmodule
